tdc_uart_readout: RTL

//  Readout end of the TDC measurement path.
//  - Captures each oTDC result word on the one-cycle done strobe and queues it in a FIFO.
//  - Serialises each queued word as a framed byte stream on an 8N1 UART line for the host.
//  - Sits in the clk0 domain directly after the TDC top.

---
 rtl/tdc_uart_readout.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/tdc_uart_readout.sv
// rtl/tdc_uart_readout.sv - TDC result FIFO and 8N1 UART packet serialiser
// Optional macro TDC_READOUT_SEQ_EN inserts a per-word sequence byte after the 0xA5 sync byte.
module tdc_uart_readout #(
  parameter int DATA_W       = 24,
  parameter int FIFO_DEPTH   = 16,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                          clk,
  input  logic                          iRst,
  input  logic [DATA_W-1:0]             iTDC,
  input  logic                          iDone,
  output logic                          oTx,
  output logic                          oBusy,
  output logic                          oOverflow,
  output logic [$clog2(FIFO_DEPTH):0]   oLevel
);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int NB     = (DATA_W + 7) / 8;
  localparam int DPAD_W = NB * 8;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
`ifdef TDC_READOUT_SEQ_EN
  localparam int SEQ_W  = 8;
`else
  localparam int SEQ_W  = 0;
`endif
  localparam int ENTRY_W = DATA_W + SEQ_W;
  localparam int NBYTES  = 1 + SEQ_W / 8 + NB;
  localparam int PKT_W   = NBYTES * 8;
  localparam int BI_W    = $clog2(NBYTES);
  localparam logic [AW:0] PTR_ONE = 1;

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

  state_t               state;
  logic [ENTRY_W-1:0]   mem [FIFO_DEPTH];
  logic [ENTRY_W-1:0]   head_q;
  logic [ENTRY_W-1:0]   wr_entry;
  logic [AW:0]          wr_ptr, rd_ptr;
  logic                 full, empty, push, pop, ready_q;
  logic [PKT_W-1:0]     pkt, pkt_load;
  logic [7:0]           sh;
  logic [BAUD_W-1:0]    baud;
  logic [2:0]           bit_idx;
  logic [BI_W-1:0]      byte_idx;
  logic                 baud_end;

  assign oLevel   = wr_ptr - rd_ptr;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push     = iDone && !full;
  assign pop      = (state == LOAD);
  assign baud_end = (baud == BAUD_W'(CLKS_PER_BIT - 1));
  assign oBusy    = !empty || (state != IDLE);

`ifdef TDC_READOUT_SEQ_EN
  logic [7:0] seq_cnt;

  // Counts every strobe, dropped or not, so the host sees a gap on overflow.
  always_ff @(posedge clk or posedge iRst) begin
    if (iRst)       seq_cnt <= '0;
    else if (iDone) seq_cnt <= seq_cnt + 8'd1;
  end

  assign wr_entry = {seq_cnt, iTDC};
  assign pkt_load = {8'hA5, head_q[ENTRY_W-1 -: 8], DPAD_W'(head_q[DATA_W-1:0])};
`else
  assign wr_entry = iTDC;
  assign pkt_load = {8'hA5, DPAD_W'(head_q)};
`endif

  // Synchronous-read storage: the head word is registered every cycle.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_entry;
    head_q <= mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk or posedge iRst) begin
    if (iRst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      oOverflow <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      if (push)          wr_ptr    <= wr_ptr + PTR_ONE;
      if (pop)           rd_ptr    <= rd_ptr + PTR_ONE;
      if (iDone && full) oOverflow <= 1'b1;
      ready_q <= !empty;
    end
  end

  always_ff @(posedge clk or posedge iRst) begin
    if (iRst) begin
      state    <= IDLE;
      oTx      <= 1'b1;
      baud     <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      pkt      <= '0;
      sh       <= '0;
    end else begin
      case (state)
        // A fresh word waits one settled cycle before a packet starts.
        IDLE: if (ready_q && !empty) state <= LOAD;
        LOAD: begin
          pkt      <= pkt_load;
          byte_idx <= '0;
          baud     <= '0;
          oTx      <= 1'b0;
          state    <= START;
        end
        START: begin
          if (baud_end) begin
            baud    <= '0;
            sh      <= pkt[PKT_W-1 -: 8];
            pkt     <= pkt << 8;
            oTx     <= pkt[PKT_W-8];
            bit_idx <= '0;
            state   <= DATA;
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        DATA: begin
          if (baud_end) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              oTx   <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              oTx     <= sh[bit_idx + 3'd1];
            end
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        STOP: begin
          if (baud_end) begin
            baud <= '0;
            if (byte_idx == BI_W'(NBYTES - 1)) begin
              state <= empty ? IDLE : LOAD;
            end else begin
              byte_idx <= byte_idx + BI_W'(1);
              oTx      <= 1'b0;
              state    <= START;
            end
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
